// File: rtl/snake_pixel_renderer.sv
// Pixel pipeline between the VGA sync generator and the DAC: tracks x/y, reads the
// snake board RAM for the current cell and paints walls, gridlines and cell contents.
module snake_pixel_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CELL_SHIFT = 4,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int ADDR_W     = 11
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic              blank_n_in,
    input  logic              vblank_n_in,
    output logic [ADDR_W-1:0] cell_addr,
    input  logic [1:0]        cell_data,
    output logic [7:0]        r,
    output logic [7:0]        g,
    output logic [7:0]        b,
    output logic              blank_n_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic              frame_tick
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int CW = XW - CELL_SHIFT;
    localparam int RW = YW - CELL_SHIFT;

    localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(GRID_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(GRID_H - 1);

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          blank_q;
    logic          vblank_q;

    logic [CW-1:0]     col_raw;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row_raw;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr_next;
    logic              wall_next;
    logic              grid_next;

    logic wall1, grid1, blank1, hs1, vs1;
    logic wall2, grid2, blank2, hs2, vs2;
    logic [23:0] rgb_next;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt <= '0;
        end else if (!blank_n_in) begin
            x_cnt <= '0;
        end else if (x_cnt != X_MAX) begin
            x_cnt <= x_cnt + 1'b1;
        end
    end

    // A line ends on the first blank cycle after active pixels; vblank clears take priority.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            y_cnt <= '0;
        end else if (!vblank_n_in) begin
            y_cnt <= '0;
        end else if (blank_q && !blank_n_in && (y_cnt != Y_MAX)) begin
            y_cnt <= y_cnt + 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            blank_q    <= 1'b0;
            vblank_q   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            blank_q    <= blank_n_in;
            vblank_q   <= vblank_n_in;
            frame_tick <= vblank_q & ~vblank_n_in;
        end
    end

    always_comb begin
        col_raw   = x_cnt[XW-1:CELL_SHIFT];
        row_raw   = y_cnt[YW-1:CELL_SHIFT];
        col       = (col_raw > COL_MAX) ? COL_MAX : col_raw;
        row       = (row_raw > ROW_MAX) ? ROW_MAX : row_raw;
        addr_next = ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col);
        wall_next = (col == '0) || (col == COL_MAX) || (row == '0) || (row == ROW_MAX);
        grid_next = (x_cnt[CELL_SHIFT-1:0] == '0) || (y_cnt[CELL_SHIFT-1:0] == '0);
    end

    // Stage 1 launches the RAM read; stage 2 waits out its one-cycle latency.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_addr <= '0;
            wall1     <= 1'b0;
            grid1     <= 1'b0;
            blank1    <= 1'b0;
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            wall2     <= 1'b0;
            grid2     <= 1'b0;
            blank2    <= 1'b0;
            hs2       <= 1'b1;
            vs2       <= 1'b1;
        end else begin
            cell_addr <= addr_next;
            wall1     <= wall_next;
            grid1     <= grid_next;
            blank1    <= blank_n_in;
            hs1       <= hs_in;
            vs1       <= vs_in;
            wall2     <= wall1;
            grid2     <= grid1;
            blank2    <= blank1;
            hs2       <= hs1;
            vs2       <= vs1;
        end
    end

    always_comb begin
        rgb_next = 24'h000000;
        if (!blank2) begin
            rgb_next = 24'h000000;
        end else if (wall2) begin
            rgb_next = 24'hFFFFFF;
        end else if (cell_data == 2'd3) begin
            rgb_next = 24'hFF0000;
        end else if (cell_data == 2'd2) begin
            rgb_next = 24'hFFFF00;
        end else if (cell_data == 2'd1) begin
            rgb_next = 24'h00C000;
        end else if (grid2) begin
            rgb_next = 24'h202020;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r           <= 8'h00;
            g           <= 8'h00;
            b           <= 8'h00;
            blank_n_out <= 1'b0;
            hs_out      <= 1'b1;
            vs_out      <= 1'b1;
        end else begin
            r           <= rgb_next[23:16];
            g           <= rgb_next[15:8];
            b           <= rgb_next[7:0];
            blank_n_out <= blank2;
            hs_out      <= hs2;
            vs_out      <= vs2;
        end
    end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Self-checking bench for snake_pixel_renderer: frame-structured stimulus with random
// boards and line lengths, compared every cycle against a coordinate-level pixel model.
module tb_snake_pixel_renderer;

    logic        vga_clk     = 1'b0;
    logic        reset_n     = 1'b0;
    logic        hs_in       = 1'b1;
    logic        vs_in       = 1'b1;
    logic        blank_n_in  = 1'b0;
    logic        vblank_n_in = 1'b0;
    logic [10:0] cell_addr;
    logic [1:0]  cell_data   = 2'd0;
    logic [7:0]  r, g, b;
    logic        blank_n_out, hs_out, vs_out, frame_tick;

    snake_pixel_renderer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .blank_n_in  (blank_n_in),
        .vblank_n_in (vblank_n_in),
        .cell_addr   (cell_addr),
        .cell_data   (cell_data),
        .r           (r),
        .g           (g),
        .b           (b),
        .blank_n_out (blank_n_out),
        .hs_out      (hs_out),
        .vs_out      (vs_out),
        .frame_tick  (frame_tick)
    );

    always #5 vga_clk = ~vga_clk;

    logic [1:0] board [0:2047];
    always @(posedge vga_clk) cell_data <= board[cell_addr];

    int checks     = 0;
    int failures   = 0;
    int tick_count = 0;
    int cur_px     = 0;
    int cur_py     = 0;
    int phase      = 0;

    logic [23:0] obs_head_a   = 24'hx;
    logic [23:0] obs_head_b   = 24'hx;
    logic [23:0] obs_grid_32  = 24'hx;
    logic [23:0] obs_grid_40  = 24'hx;
    logic [23:0] obs_dark     = 24'hx;
    logic [23:0] obs_wall     = 24'hx;
    logic [23:0] obs_corner   = 24'hx;
    logic [10:0] obs_addr81   = 11'hx;
    logic [10:0] obs_addr1199 = 11'hx;

    function automatic int imin(input int a, input int m);
        return (a > m) ? m : a;
    endfunction

    function automatic int cell_of(input int px, input int py);
        return imin(py / 16, 29) * 40 + imin(px / 16, 39);
    endfunction

    // Colour a visible pixel at screen coordinates directly from the painting rules.
    function automatic logic [23:0] pixel_color(input int px, input int py);
        int col = imin(px / 16, 39);
        int row = imin(py / 16, 29);
        if (col == 0 || col == 39 || row == 0 || row == 29) return 24'hFFFFFF;
        case (board[row * 40 + col])
            2'd3:    return 24'hFF0000;
            2'd2:    return 24'hFFFF00;
            2'd1:    return 24'h00C000;
            default: ;
        endcase
        if (px % 16 == 0 || py % 16 == 0) return 24'h202020;
        return 24'h000000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rgb"}, {8'h0, r, g, b}, 32'h0);
        check({tag, "_blank"}, {31'h0, blank_n_out}, 32'h0);
        check({tag, "_hs"}, {31'h0, hs_out}, 32'h1);
        check({tag, "_vs"}, {31'h0, vs_out}, 32'h1);
        check({tag, "_addr"}, {21'h0, cell_addr}, 32'h0);
        check({tag, "_tick"}, {31'h0, frame_tick}, 32'h0);
    endtask

    task automatic drive(input bit bl, input bit vb, input bit hs, input bit vs,
                         input int px, input int py);
        @(negedge vga_clk);
        blank_n_in  = bl;
        vblank_n_in = vb;
        hs_in       = hs;
        vs_in       = vs;
        cur_px      = px;
        cur_py      = py;
    endtask

    task automatic drive_line(input int act, input int blk, input int line,
                              input bit vb, input bit vs_lo);
        for (int i = 0; i < act; i++)
            drive(1'b1, vb, 1'b1, !vs_lo, imin(i, 639), imin(line, 479));
        for (int j = 0; j < blk; j++)
            drive(1'b0, vb, !(j >= blk / 4 && j < blk / 2), !vs_lo, 0, 0);
    endtask

    task automatic vblank_lines(input int n, input int len);
        for (int v = 0; v < n; v++) drive_line(0, len, 0, 1'b0, (v == 1 || v == 2));
    endtask

    task automatic drive_random_inputs();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    endtask

    task automatic randomize_board();
        for (int i = 0; i < 2048; i++) board[i] = 2'($urandom);
    endtask

    // Per-cycle reference: history of sampled inputs and the colour each sample must produce.
    logic        hb   [0:2];
    logic        hhs  [0:2];
    logic        hvs  [0:2];
    logic [23:0] hrgb [0:2];
    int          hpx  [0:2];
    int          hpy  [0:2];
    int          hph  [0:2];
    logic        prev_vb = 1'b0;
    logic        exp_tick;
    int          exp_addr;

    always @(posedge vga_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                hb[i] = 1'b0; hhs[i] = 1'b1; hvs[i] = 1'b1; hrgb[i] = 24'h0;
                hpx[i] = 0; hpy[i] = 0; hph[i] = 0;
            end
            prev_vb = 1'b0;
        end else begin
            for (int i = 2; i > 0; i--) begin
                hb[i] = hb[i-1]; hhs[i] = hhs[i-1]; hvs[i] = hvs[i-1];
                hrgb[i] = hrgb[i-1]; hpx[i] = hpx[i-1]; hpy[i] = hpy[i-1]; hph[i] = hph[i-1];
            end
            hb[0]   = blank_n_in;
            hhs[0]  = hs_in;
            hvs[0]  = vs_in;
            hpx[0]  = cur_px;
            hpy[0]  = cur_py;
            hph[0]  = phase;
            hrgb[0] = blank_n_in ? pixel_color(cur_px, cur_py) : 24'h0;
            exp_tick = prev_vb && !vblank_n_in;
            prev_vb  = vblank_n_in;
            exp_addr = cell_of(cur_px, cur_py);
            #1;
            check("rgb", {8'h0, r, g, b}, {8'h0, hrgb[2]});
            check("blank_n_out", {31'h0, blank_n_out}, {31'h0, hb[2]});
            check("hs_out", {31'h0, hs_out}, {31'h0, hhs[2]});
            check("vs_out", {31'h0, vs_out}, {31'h0, hvs[2]});
            check("frame_tick", {31'h0, frame_tick}, {31'h0, exp_tick});
            if (hb[0]) check("cell_addr", {21'h0, cell_addr}, 32'(exp_addr));
            if (frame_tick) tick_count++;
            if (hb[0] && hph[0] == 1 && hpx[0] == 17 && hpy[0] == 33) obs_addr81 = cell_addr;
            if (hb[0] && hph[0] == 2 && hpx[0] == 639 && hpy[0] == 479) obs_addr1199 = cell_addr;
            if (hb[2] && hph[2] == 1) begin
                if (hpx[2] == 20 && hpy[2] == 16) obs_head_a  = {r, g, b};
                if (hpx[2] == 31 && hpy[2] == 16) obs_head_b  = {r, g, b};
                if (hpx[2] == 32 && hpy[2] == 16) obs_grid_32 = {r, g, b};
                if (hpx[2] == 32 && hpy[2] == 40) obs_grid_40 = {r, g, b};
                if (hpx[2] == 40 && hpy[2] == 40) obs_dark    = {r, g, b};
                if (hpx[2] == 5  && hpy[2] == 5)  obs_wall    = {r, g, b};
            end
            if (hb[2] && hph[2] == 2 && hpx[2] == 639 && hpy[2] == 479) obs_corner = {r, g, b};
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) board[i] = 2'd0;

        $display("[TB] reset hold with random inputs");
        repeat (8) begin
            drive_random_inputs();
            @(posedge vga_clk);
            #1;
            check_reset_vals("reset_hold");
        end
        @(negedge vga_clk);
        blank_n_in = 1'b0; vblank_n_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        cur_px = 0; cur_py = 0;
        reset_n = 1'b1;
        vblank_lines(3, 660);

        $display("[TB] frame A: empty board with head at cell 41");
        phase = 1;
        board[41] = 2'd2;
        for (int l = 0; l < 44; l++) drive_line(640, 20, l, 1'b1, 1'b0);
        vblank_lines(4, 660);

        $display("[TB] frame B: random board, narrow lines, full-width bottom");
        phase = 2;
        randomize_board();
        for (int l = 0; l < 490; l++) begin
            if (l < 487) drive_line($urandom_range(40, 8), $urandom_range(12, 4), l, 1'b1, 1'b0);
            else         drive_line(640, 20, l, 1'b1, 1'b0);
        end
        vblank_lines(4, 100);

        $display("[TB] frame C: random board with a held-active line");
        phase = 3;
        randomize_board();
        for (int l = 0; l < 20; l++) begin
            if (l == 2) begin
                for (int i = 0; i < 700; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, imin(i, 639), 2);
                @(posedge vga_clk);
                #1;
                check("held_addr_col39", {21'h0, cell_addr}, 32'd39);
                drive_line(0, 10, l, 1'b1, 1'b0);
            end else begin
                drive_line($urandom_range(200, 1), $urandom_range(16, 4), l, 1'b1, 1'b0);
            end
        end
        vblank_lines(4, 100);

        $display("[TB] frame D: asynchronous reset mid-line");
        phase = 4;
        for (int l = 0; l < 5; l++) drive_line(100, 10, l, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 1'b1, 1'b1, i, 5);
        @(posedge vga_clk);
        #1;
        check("pre_reset_white", {8'h0, r, g, b}, 32'h00FFFFFF);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        repeat (3) drive_random_inputs();
        @(negedge vga_clk);
        blank_n_in = 1'b0; vblank_n_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        cur_px = 0; cur_py = 0;
        reset_n = 1'b1;
        vblank_lines(2, 80);

        $display("[TB] frame E: recovery after reset");
        phase = 5;
        randomize_board();
        for (int l = 0; l < 24; l++) drive_line($urandom_range(120, 1), $urandom_range(10, 4), l, 1'b1, 1'b0);
        vblank_lines(4, 60);

        check("head_px20_line16", {8'h0, obs_head_a}, 32'h00FFFF00);
        check("head_px31_line16", {8'h0, obs_head_b}, 32'h00FFFF00);
        check("grid_px32_line16", {8'h0, obs_grid_32}, 32'h00202020);
        check("grid_px32_line40", {8'h0, obs_grid_40}, 32'h00202020);
        check("dark_px40_line40", {8'h0, obs_dark}, 32'h00000000);
        check("wall_px5_line5", {8'h0, obs_wall}, 32'h00FFFFFF);
        check("corner_wall", {8'h0, obs_corner}, 32'h00FFFFFF);
        check("addr_17_33", {21'h0, obs_addr81}, 32'd81);
        check("addr_639_479", {21'h0, obs_addr1199}, 32'd1199);
        check("frame_tick_count", 32'(tick_count), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
